// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the sram-like request arbiter.
package sram_req_arbiter_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Originator tag stored per accepted request.
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLockI = 2'd1,
    StLockD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order 1-bit tag FIFO: remembers who owns each outstanding request.
module sram_req_arbiter_tag_fifo #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            push_tag,
  input  logic            pop,
  output logic            pop_tag,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en, full;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign pop_tag = mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + CntW'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Storage and pointers; a single-entry FIFO keeps its pointers at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_tag;
        wr_ptr_q        <= (Depth == 1) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= (Depth == 1) ? '0 : rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between fetch (inst) and execute (data) requesters.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW    = $clog2(OUTSTANDING) + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_e         state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               starve_full, can_grant;
  logic               gnt_valid, gnt_tag;
  logic               push, pop, head_tag, tag_empty;
  logic [CntW-1:0]    tag_count;

  // Registered count only: a same-cycle pop never frees a slot for a grant.
  assign can_grant   = (tag_count < CntW'(OUTSTANDING));
  assign starve_full = (starve_q == StarveW'(STARVE_LIMIT));
  assign push        = gnt_valid && mem_addr_ok;
  assign pop         = mem_data_ok && !tag_empty;

  // Grant selection and lock FSM: grant is held stable until mem_addr_ok.
  always_comb begin
    state_d   = state_q;
    gnt_valid = 1'b0;
    gnt_tag   = TAG_DATA;
    unique case (state_q)
      StIdle: begin
        if (can_grant && (inst_req || data_req)) begin
          gnt_valid = 1'b1;
          gnt_tag   = (data_req && !(inst_req && starve_full)) ? TAG_DATA : TAG_INST;
          if (!mem_addr_ok) begin
            state_d = (gnt_tag == TAG_DATA) ? StLockD : StLockI;
          end
        end
      end
      StLockI: begin
        // Held even if inst drops its request.
        gnt_valid = 1'b1;
        gnt_tag   = TAG_INST;
        if (mem_addr_ok) state_d = StIdle;
      end
      StLockD: begin
        gnt_valid = 1'b1;
        gnt_tag   = TAG_DATA;
        if (mem_addr_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Downstream request mux and per-requester handshakes.
  always_comb begin
    mem_req      = gnt_valid;
    mem_wr       = data_wr;
    mem_size     = data_size;
    mem_wstrb    = data_wstrb;
    mem_addr     = data_addr;
    mem_wdata    = data_wdata;
    if (gnt_tag == TAG_INST) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
    inst_addr_ok = push && (gnt_tag == TAG_INST);
    data_addr_ok = push && (gnt_tag == TAG_DATA);
    inst_data_ok = pop && (head_tag == TAG_INST);
    data_data_ok = pop && (head_tag == TAG_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // Starvation counter: data acceptances while inst waits; cleared by an inst acceptance.
  always_comb begin
    starve_d = starve_q;
    if (push) begin
      if (gnt_tag == TAG_INST) begin
        starve_d = '0;
      end else if (inst_req && !starve_full) begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  sram_req_arbiter_tag_fifo #(
    .Depth(OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .push_tag(gnt_tag),
    .pop     (pop),
    .pop_tag (head_tag),
    .empty   (tag_empty),
    .count   (tag_count)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: expected tags queued on acceptance, checked on response.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam logic [31:0] I_ADDR  = 32'h0000_2000;
  localparam logic [31:0] D_ADDR  = 32'h0000_1000;
  localparam logic [31:0] I_WDATA = 32'h1234_5678;
  localparam logic [31:0] D_WDATA = 32'hCAFE_F00D;

  logic        clk, rstn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];

  sram_req_arbiter #(
    .OUTSTANDING (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_wstrb  (inst_wstrb),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Grant check; an accepted grant queues its expected response tag.
  task automatic chk_gnt(input bit valid, input bit tag);
    chk("mem_req", mem_req, valid);
    if (valid) begin
      chk("mem_addr", mem_addr, (tag == TAG_INST) ? I_ADDR : D_ADDR);
      chk("mem_wdata", mem_wdata, (tag == TAG_INST) ? I_WDATA : D_WDATA);
    end
    chk("inst_addr_ok", inst_addr_ok, valid && mem_addr_ok && (tag == TAG_INST));
    chk("data_addr_ok", data_addr_ok, valid && mem_addr_ok && (tag == TAG_DATA));
    if (valid && mem_addr_ok) exp_q.push_back(tag);
  endtask

  // Response check against the oldest queued tag.
  task automatic chk_rsp(input logic [31:0] rd);
    bit t;
    chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    chk("inst_data_ok", inst_data_ok, t == TAG_INST);
    chk("data_data_ok", data_data_ok, t == TAG_DATA);
    if (t == TAG_INST) chk("inst_rdata", inst_rdata, rd);
    else               chk("data_rdata", data_rdata, rd);
  endtask

  task automatic chk_quiet();
    chk("q_mem_req", mem_req, 1'b0);
    chk("q_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("q_data_addr_ok", data_addr_ok, 1'b0);
    chk("q_inst_data_ok", inst_data_ok, 1'b0);
    chk("q_data_data_ok", data_data_ok, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = MEM_SIZE_WORD; inst_wstrb = 4'hF;
    inst_addr = I_ADDR; inst_wdata = I_WDATA;
    data_req = 1'b0; data_wr = 1'b1; data_size = MEM_SIZE_WORD; data_wstrb = 4'hF;
    data_addr = D_ADDR; data_wdata = D_WDATA;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (2) cyc();
    settle();
    chk_quiet();
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    chk("rst_starve", 32'(dut.starve_q), 32'd0);
    rstn = 1'b1;

    // 1: simultaneous requests, data first, responses in order
    cyc(); inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk_gnt(1'b1, TAG_DATA);
    cyc(); data_req = 1'b0; settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'hAAAA_0001; settle();
    chk_rsp(32'hAAAA_0001);
    cyc(); mem_rdata = 32'hAAAA_0002; settle();
    chk_rsp(32'hAAAA_0002);

    // 2: data grant locked for 3 cycles while inst rises
    cyc(); mem_data_ok = 1'b0; data_req = 1'b1; settle();
    chk_gnt(1'b1, TAG_DATA);
    for (int i = 0; i < 2; i++) begin
      cyc(); inst_req = 1'b1; settle();
      chk_gnt(1'b1, TAG_DATA);
    end
    chk("lock_d_state", 32'(dut.state_q), 32'(StLockD));
    cyc(); mem_addr_ok = 1'b1; settle();
    chk_gnt(1'b1, TAG_DATA);
    cyc(); data_req = 1'b0; settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'hAAAA_0003; settle();
    chk_rsp(32'hAAAA_0003);
    cyc(); mem_rdata = 32'hAAAA_0004; settle();
    chk_rsp(32'hAAAA_0004);

    // 3: FIFO full blocks grants; a pop frees a slot only next cycle
    cyc(); mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); inst_req = 1'b0; data_req = 1'b1; settle();
    chk_gnt(1'b0, TAG_DATA);
    cyc(); settle();
    chk_gnt(1'b0, TAG_DATA);
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0005; settle();
    chk_rsp(32'hAAAA_0005);
    chk_gnt(1'b0, TAG_DATA);
    cyc(); mem_data_ok = 1'b0; settle();
    chk_gnt(1'b1, TAG_DATA);
    cyc(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'hAAAA_0006; settle();
    chk_rsp(32'hAAAA_0006);
    cyc(); mem_rdata = 32'hAAAA_0007; settle();
    chk_rsp(32'hAAAA_0007);

    // Response with empty FIFO is ignored
    cyc(); settle();
    chk("err_inst_data_ok", inst_data_ok, 1'b0);
    chk("err_data_data_ok", data_data_ok, 1'b0);
    cyc(); mem_data_ok = 1'b0; settle();
    chk("err_count", 32'(dut.u_fifo.count_q), 32'd0);

    // 4: starvation limit forces inst on the 5th grant
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) cyc();
      mem_data_ok = (k > 1);
      mem_rdata = 32'h4000_0000 + 32'(k);
      settle();
      if (k > 1) chk_rsp(32'h4000_0000 + 32'(k));
      chk_gnt(1'b1, (k == 5) ? TAG_INST : TAG_DATA);
    end
    cyc(); inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h4000_0006; settle();
    chk("starve_cleared", 32'(dut.starve_q), 32'd0);
    chk_rsp(32'h4000_0006);

    // 5: response routing for tags {inst, data}
    cyc(); mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); inst_req = 1'b0; data_req = 1'b1; settle();
    chk_gnt(1'b1, TAG_DATA);
    cyc(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h1111_1111; settle();
    chk_rsp(32'h1111_1111);
    cyc(); mem_rdata = 32'h2222_2222; settle();
    chk_rsp(32'h2222_2222);

    // 6: reset with one outstanding tag and LOCK_D active
    cyc(); mem_data_ok = 1'b0; inst_req = 1'b1; mem_addr_ok = 1'b1; settle();
    chk_gnt(1'b1, TAG_INST);
    cyc(); inst_req = 1'b0; data_req = 1'b1; mem_addr_ok = 1'b0; settle();
    chk_gnt(1'b1, TAG_DATA);
    cyc(); data_req = 1'b0; rstn = 1'b0; settle();
    chk("pre_rst_state", 32'(dut.state_q), 32'(StLockD));
    chk("pre_rst_count", 32'(dut.u_fifo.count_q), 32'd1);
    cyc(); settle();
    exp_q.delete();
    chk("post_rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("post_rst_count", 32'(dut.u_fifo.count_q), 32'd0);
    chk_quiet();
    rstn = 1'b1;
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle();
    chk("drop_inst_data_ok", inst_data_ok, 1'b0);
    chk("drop_data_data_ok", data_data_ok, 1'b0);
    cyc(); mem_data_ok = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
